// File: rtl/stack_up_intf_ingress_pkg.sv
// Shared constants for the stack upstream ingress block: framing codes,
// default field widths and the framing FSM state encoding.
package stack_up_intf_ingress_pkg;

    localparam int unsigned DEPTH_DEF  = 8;
    localparam int unsigned DATA_W_DEF = 64;
    localparam int unsigned OOB_W_DEF  = 32;
    localparam int unsigned TYPE_W_DEF = 2;
    localparam int unsigned CNTL_W_DEF = 2;
    localparam int unsigned CNT_W_DEF  = 16;

    localparam logic [1:0] CNTL_SOM     = 2'b00;
    localparam logic [1:0] CNTL_MOM     = 2'b01;
    localparam logic [1:0] CNTL_EOM     = 2'b10;
    localparam logic [1:0] CNTL_SOM_EOM = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_MSG = 1'b1
    } frame_state_e;

endpackage

// File: rtl/generic_fwft_fifo.sv
// First-word-fall-through FIFO: head entry is always presented on rdata_o.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module generic_fwft_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage and write pointer; contents cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q        <= wr_ptr_q + AW'(1);
        end
    end

    // Read pointer and occupancy counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/stack_up_intf_ingress.sv
// Manager-to-stack upstream ingress: buffers manager words in a FWFT FIFO,
// checks SOM/MOM/EOM framing, and reports sticky errors and message count.
module stack_up_intf_ingress
    import stack_up_intf_ingress_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned OOB_W  = OOB_W_DEF,
    parameter int unsigned TYPE_W = TYPE_W_DEF,
    parameter int unsigned CNTL_W = CNTL_W_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              mgr__stu__valid,
    input  logic [CNTL_W-1:0] mgr__stu__cntl,
    input  logic [TYPE_W-1:0] mgr__stu__type,
    input  logic [DATA_W-1:0] mgr__stu__data,
    input  logic [OOB_W-1:0]  mgr__stu__oob_data,
    output logic              stu__mgr__ready,
    output logic              stu__stk__valid,
    output logic [CNTL_W-1:0] stu__stk__cntl,
    output logic [TYPE_W-1:0] stu__stk__type,
    output logic [DATA_W-1:0] stu__stk__data,
    output logic [OOB_W-1:0]  stu__stk__oob_data,
    input  logic              stk__stu__ready,
    output logic              stu__sys__protocolErr,
    output logic              stu__sys__overflowErr,
    output logic [CNT_W-1:0]  stu__sys__msgCount,
    output logic              stu__sys__idle
);

    localparam int unsigned WORD_W = CNTL_W + TYPE_W + OOB_W + DATA_W;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    localparam logic [CNTL_W-1:0] C_SOM     = CNTL_W'(CNTL_SOM);
    localparam logic [CNTL_W-1:0] C_MOM     = CNTL_W'(CNTL_MOM);
    localparam logic [CNTL_W-1:0] C_EOM     = CNTL_W'(CNTL_EOM);
    localparam logic [CNTL_W-1:0] C_SOM_EOM = CNTL_W'(CNTL_SOM_EOM);

    frame_state_e      state_q, state_d;
    logic              ready_q, ready_d;
    logic              perr_q, ovf_q;
    logic              perr_set, ovf_set;
    logic [CNT_W-1:0]  msg_cnt_q;
    logic              push, pop, can_write;
    logic              fifo_empty, fifo_full;
    logic [CW-1:0]     fifo_count, count_next;
    logic [WORD_W-1:0] fifo_rdata;

    generic_fwft_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset_poweron),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({mgr__stu__cntl, mgr__stu__type, mgr__stu__oob_data, mgr__stu__data}),
        .rdata_o (fifo_rdata),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign {stu__stk__cntl, stu__stk__type, stu__stk__oob_data, stu__stk__data} = fifo_rdata;
    assign stu__stk__valid       = !fifo_empty;
    assign pop                   = stu__stk__valid && stk__stu__ready;
    assign can_write             = !fifo_full || pop;
    assign stu__mgr__ready       = ready_q;
    assign stu__sys__protocolErr = perr_q;
    assign stu__sys__overflowErr = ovf_q;
    assign stu__sys__msgCount    = msg_cnt_q;
    assign stu__sys__idle        = fifo_empty && (state_q == ST_IDLE);

    // Framing decisions: overflow takes precedence and freezes the FSM;
    // otherwise the FSM picks write/drop and the next framing state.
    always_comb begin
        state_d  = state_q;
        push     = 1'b0;
        perr_set = 1'b0;
        ovf_set  = 1'b0;
        if (mgr__stu__valid) begin
            if (!can_write) begin
                ovf_set = 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (mgr__stu__cntl == C_SOM) begin
                            push    = 1'b1;
                            state_d = ST_IN_MSG;
                        end else if (mgr__stu__cntl == C_SOM_EOM) begin
                            push    = 1'b1;
                        end else begin
                            perr_set = 1'b1;
                        end
                    end
                    default: begin
                        push = 1'b1;
                        if (mgr__stu__cntl == C_EOM) begin
                            state_d = ST_IDLE;
                        end else if (mgr__stu__cntl == C_SOM) begin
                            perr_set = 1'b1;
                        end else if (mgr__stu__cntl == C_SOM_EOM) begin
                            perr_set = 1'b1;
                            state_d  = ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    // Next occupancy decides the registered back-pressure, keeping one slot spare.
    always_comb begin
        count_next = fifo_count + CW'(push) - CW'(pop);
        ready_d    = (count_next <= CW'(DEPTH - 2));
    end

    // Framing state register.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Back-pressure register, sticky error flags and delivered-message counter.
    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            ready_q   <= 1'b0;
            perr_q    <= 1'b0;
            ovf_q     <= 1'b0;
            msg_cnt_q <= '0;
        end else begin
            ready_q <= ready_d;
            if (perr_set) begin
                perr_q <= 1'b1;
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
            if (pop && (stu__stk__cntl == C_EOM || stu__stk__cntl == C_SOM_EOM)) begin
                msg_cnt_q <= msg_cnt_q + CNT_W'(1);
            end
        end
    end

endmodule
